// File: rtl/mem_port_arbiter.sv
// Three-way arbiter (fetch / load / store) in front of the single byte-serial memory controller.
// Optional ARB_STATS_EN adds wrapping grant/stall/drop counters.
module mem_port_arbiter #(
  parameter int                ADDR_W       = 32,
  parameter int                STARVE_LIMIT = 4,
  parameter logic [ADDR_W-1:0] IO_BASE      = ADDR_W'(32'h30000)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [ADDR_W-1:0] if_data,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [2:0]        ld_len,
  output logic              ld_done,
  output logic [ADDR_W-1:0] ld_data,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [2:0]        st_len,
  input  logic [ADDR_W-1:0] st_data,
  output logic              st_done,
  input  logic              io_buffer_full,
  output logic              dn_valid,
  output logic              dn_write,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [2:0]        dn_len,
  output logic [ADDR_W-1:0] dn_wdata,
  input  logic              dn_done,
  input  logic [ADDR_W-1:0] dn_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       stat_if_grants,
  output logic [31:0]       stat_ld_grants,
  output logic [31:0]       stat_st_grants,
  output logic [31:0]       stat_io_stall,
  output logic [31:0]       stat_drops
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LD, OWN_ST} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d, win;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              drop_q, drop_d;
  logic              dn_valid_q, dn_valid_d, dn_write_q, dn_write_d;
  logic [ADDR_W-1:0] dn_addr_q, dn_addr_d, dn_wdata_q, dn_wdata_d;
  logic [2:0]        dn_len_q, dn_len_d;
  logic [ADDR_W-1:0] rdata_q, rdata_d, if_data_q, if_data_d, ld_data_q, ld_data_d;
  logic              if_done_q, if_done_d, ld_done_q, ld_done_d, st_done_q, st_done_d;
  logic              io_blocked, st_ok, starved, grant;

  function automatic logic [2:0] norm_len(input logic [2:0] l);
    case (l)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] len_mask(input logic [2:0] l);
    case (l)
      3'd1:    return ADDR_W'(8'hFF);
      3'd2:    return ADDR_W'(16'hFFFF);
      default: return '1;
    endcase
  endfunction

  assign io_blocked = (st_addr >= IO_BASE) && io_buffer_full;
  assign st_ok      = st_req && !io_blocked;
  assign starved    = if_req && (starve_cnt_q == 4'(STARVE_LIMIT));

  always_comb begin
    win = OWN_NONE;
    if (st_ok)        win = OWN_ST;
    else if (starved) win = OWN_IF;
    else if (ld_req)  win = OWN_LD;
    else if (if_req)  win = OWN_IF;
  end

  // A flush cancels a speculative fetch/load grant, but a store is architecturally committed.
  assign grant = (state_q == IDLE) && (win == OWN_ST || (win != OWN_NONE && !clear));

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    drop_d       = drop_q;
    dn_valid_d   = dn_valid_q;
    dn_write_d   = dn_write_q;
    dn_addr_d    = dn_addr_q;
    dn_len_d     = dn_len_q;
    dn_wdata_d   = dn_wdata_q;
    rdata_d      = rdata_q;
    if_done_d    = if_done_q;
    if_data_d    = if_data_q;
    ld_done_d    = ld_done_q;
    ld_data_d    = ld_data_q;
    st_done_d    = st_done_q;
    if (rdy_in) begin
      dn_valid_d = 1'b0;
      if_done_d  = 1'b0;
      ld_done_d  = 1'b0;
      st_done_d  = 1'b0;
      if (!if_req)                              starve_cnt_d = '0;
      else if (grant && win == OWN_IF)          starve_cnt_d = '0;
      else if (grant && starve_cnt_q != 4'hF)   starve_cnt_d = starve_cnt_q + 4'd1;
      case (state_q)
        IDLE: if (grant) begin
          owner_d    = win;
          state_d    = ISSUE;
          dn_valid_d = 1'b1;
          dn_write_d = (win == OWN_ST);
          case (win)
            OWN_ST: begin dn_addr_d = st_addr; dn_len_d = norm_len(st_len); dn_wdata_d = st_data; end
            OWN_LD: begin dn_addr_d = ld_addr; dn_len_d = norm_len(ld_len); dn_wdata_d = '0; end
            default: begin dn_addr_d = if_addr; dn_len_d = 3'd4; dn_wdata_d = '0; end
          endcase
        end
        ISSUE: begin
          state_d = BUSY;
          if (clear && owner_q != OWN_ST) drop_d = 1'b1;
        end
        BUSY: begin
          if (clear && owner_q != OWN_ST) drop_d = 1'b1;
          if (dn_done) begin
            rdata_d = dn_rdata;
            state_d = RESP;
          end
        end
        RESP: begin
          if (!drop_q) begin
            case (owner_q)
              OWN_IF: begin if_done_d = 1'b1; if_data_d = rdata_q; end
              OWN_LD: begin ld_done_d = 1'b1; ld_data_d = rdata_q & len_mask(dn_len_q); end
              OWN_ST: st_done_d = 1'b1;
              default: ;
            endcase
          end
          drop_d  = 1'b0;
          owner_d = OWN_NONE;
          state_d = IDLE;
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [31:0] st_if_q, st_ld_q, st_st_q, st_stall_q, st_drop_q;
  logic [31:0] st_if_d, st_ld_d, st_st_d, st_stall_d, st_drop_d;

  always_comb begin
    st_if_d    = st_if_q    + 32'((rdy_in && grant && win == OWN_IF) ? 1 : 0);
    st_ld_d    = st_ld_q    + 32'((rdy_in && grant && win == OWN_LD) ? 1 : 0);
    st_st_d    = st_st_q    + 32'((rdy_in && grant && win == OWN_ST) ? 1 : 0);
    st_stall_d = st_stall_q + 32'((rdy_in && state_q == IDLE && st_req && io_blocked) ? 1 : 0);
    st_drop_d  = st_drop_q  + 32'((rdy_in && state_q == RESP && drop_q) ? 1 : 0);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      st_if_q <= '0; st_ld_q <= '0; st_st_q <= '0; st_stall_q <= '0; st_drop_q <= '0;
    end else begin
      st_if_q <= st_if_d; st_ld_q <= st_ld_d; st_st_q <= st_st_d;
      st_stall_q <= st_stall_d; st_drop_q <= st_drop_d;
    end
  end

  assign stat_if_grants = st_if_q;
  assign stat_ld_grants = st_ld_q;
  assign stat_st_grants = st_st_q;
  assign stat_io_stall  = st_stall_q;
  assign stat_drops     = st_drop_q;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      owner_q      <= OWN_NONE;
      starve_cnt_q <= '0;
      drop_q       <= 1'b0;
      dn_valid_q   <= 1'b0;
      dn_write_q   <= 1'b0;
      dn_addr_q    <= '0;
      dn_len_q     <= '0;
      dn_wdata_q   <= '0;
      rdata_q      <= '0;
      if_done_q    <= 1'b0;
      if_data_q    <= '0;
      ld_done_q    <= 1'b0;
      ld_data_q    <= '0;
      st_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      drop_q       <= drop_d;
      dn_valid_q   <= dn_valid_d;
      dn_write_q   <= dn_write_d;
      dn_addr_q    <= dn_addr_d;
      dn_len_q     <= dn_len_d;
      dn_wdata_q   <= dn_wdata_d;
      rdata_q      <= rdata_d;
      if_done_q    <= if_done_d;
      if_data_q    <= if_data_d;
      ld_done_q    <= ld_done_d;
      ld_data_q    <= ld_data_d;
      st_done_q    <= st_done_d;
    end
  end

  assign dn_valid = dn_valid_q;
  assign dn_write = dn_write_q;
  assign dn_addr  = dn_addr_q;
  assign dn_len   = dn_len_q;
  assign dn_wdata = dn_wdata_q;
  assign if_done  = if_done_q;
  assign if_data  = if_data_q;
  assign ld_done  = ld_done_q;
  assign ld_data  = ld_data_q;
  assign st_done  = st_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected issues/responses, a monitor checks them.
module tb_mem_port_arbiter;
  logic        clk_in = 1'b0, rst_in, rdy_in, clear;
  logic        if_req, if_done, ld_req, ld_done, st_req, st_done, io_buffer_full;
  logic [31:0] if_addr, if_data, ld_addr, ld_data, st_addr, st_data;
  logic [2:0]  ld_len, st_len, dn_len;
  logic        dn_valid, dn_write, dn_done;
  logic [31:0] dn_addr, dn_wdata, dn_rdata;

  int n_tests = 0, n_fail = 0, n_issue = 0, kick = 0;
  bit ctl_en = 1'b1;

  typedef struct { logic w; logic [31:0] a; logic [2:0] l; logic [31:0] d; } dn_exp_t;
  typedef struct { int who; logic [31:0] data; } rsp_exp_t;
  dn_exp_t  exp_dn[$];
  rsp_exp_t exp_rsp[$];
  dn_exp_t  m_dn;
  rsp_exp_t m_rsp;
  int       m_who;

  mem_port_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_len(ld_len), .ld_done(ld_done), .ld_data(ld_data),
    .st_req(st_req), .st_addr(st_addr), .st_len(st_len), .st_data(st_data), .st_done(st_done),
    .io_buffer_full(io_buffer_full),
    .dn_valid(dn_valid), .dn_write(dn_write), .dn_addr(dn_addr), .dn_len(dn_len),
    .dn_wdata(dn_wdata), .dn_done(dn_done), .dn_rdata(dn_rdata)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h1000) return 32'hDEADBEEF;
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic exp_issue(input logic w, input logic [31:0] a, input logic [2:0] l, input logic [31:0] d);
    dn_exp_t e;
    e.w = w; e.a = a; e.l = l; e.d = d;
    exp_dn.push_back(e);
  endtask

  task automatic exp_resp(input int who, input logic [31:0] d);
    rsp_exp_t r;
    r.who = who; r.data = d;
    exp_rsp.push_back(r);
  endtask

  // Controller model: answers each issue a few cycles later; 'kick' forces a stray done.
  initial begin
    int          wait_n, kick_seen;
    logic [31:0] resp;
    wait_n = -1; kick_seen = 0; resp = '0;
    dn_done = 1'b0; dn_rdata = '0;
    forever begin
      @(negedge clk_in);
      dn_done = 1'b0; dn_rdata = '0;
      if (wait_n > 0) wait_n--;
      else if (wait_n == 0) begin dn_done = 1'b1; dn_rdata = resp; wait_n = -1; end
      if (dn_valid && ctl_en) begin
        wait_n = 2;
        resp = dn_write ? 32'h0 : rd_model(dn_addr);
      end
      if (kick != kick_seen) begin kick_seen = kick; dn_done = 1'b1; dn_rdata = 32'hBAD0BAD0; end
    end
  end

  always @(negedge clk_in) begin
    if (dn_valid) begin
      n_issue++;
      if (exp_dn.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dn_issue: unexpected issue at addr %h, expected none", dn_addr);
      end else begin
        m_dn = exp_dn.pop_front();
        chk("dn_write", 32'(dn_write), 32'(m_dn.w));
        chk("dn_addr", dn_addr, m_dn.a);
        chk("dn_len", 32'(dn_len), 32'(m_dn.l));
        chk("dn_wdata", dn_wdata, m_dn.d);
      end
    end
    if (if_done || ld_done || st_done) begin
      m_who = if_done ? 0 : (ld_done ? 1 : 2);
      chk("done_onehot", 32'(if_done) + 32'(ld_done) + 32'(st_done), 32'd1);
      if (exp_rsp.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL done: unexpected done for requester %0d, expected none", m_who);
      end else begin
        m_rsp = exp_rsp.pop_front();
        chk("done_owner", 32'(m_who), 32'(m_rsp.who));
        if (m_who == 0) chk("if_data", if_data, m_rsp.data);
        if (m_who == 1) chk("ld_data", ld_data, m_rsp.data);
      end
    end
  end

  task automatic do_fetch(input logic [31:0] a);
    bit seen = 1'b0;
    if_addr = a; if_req = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk_in); if (if_done) seen = 1'b1; end
    if_req = 1'b0;
    chk("fetch_wait", 32'(seen), 32'd1);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] l);
    bit seen = 1'b0;
    ld_addr = a; ld_len = l; ld_req = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk_in); if (ld_done) seen = 1'b1; end
    ld_req = 1'b0;
    chk("load_wait", 32'(seen), 32'd1);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [2:0] l, input logic [31:0] d);
    bit seen = 1'b0;
    st_addr = a; st_len = l; st_data = d; st_req = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk_in); if (st_done) seen = 1'b1; end
    st_req = 1'b0;
    chk("store_wait", 32'(seen), 32'd1);
  endtask

  task automatic wait_issue();
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk_in); if (dn_valid) seen = 1'b1; end
    chk("issue_wait", 32'(seen), 32'd1);
  endtask

  initial begin
    int base;
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
    if_addr = '0; ld_addr = '0; st_addr = '0; st_data = '0; ld_len = 3'd4; st_len = 3'd4;
    repeat (2) @(negedge clk_in);
    chk("rst_dn_valid", 32'(dn_valid), 0);
    chk("rst_dn_addr", dn_addr, 0);
    chk("rst_dn_len", 32'(dn_len), 0);
    chk("rst_dones", 32'(if_done) + 32'(ld_done) + 32'(st_done), 0);
    chk("rst_state", 32'(dut.state_q), 0);
    rst_in = 1'b0;
    @(negedge clk_in);

    // rdy_in low freezes arbitration, then a single fetch
    rdy_in = 1'b0; if_addr = 32'h1000; if_req = 1'b1;
    repeat (5) @(negedge clk_in);
    chk("rdy_hold_no_issue", 32'(n_issue), 0);
    rdy_in = 1'b1;
    exp_issue(1'b0, 32'h1000, 3'd4, 32'h0); exp_resp(0, 32'hDEADBEEF);
    do_fetch(32'h1000);
    repeat (2) @(negedge clk_in);

    // all three at once: store, load, fetch
    exp_issue(1'b1, 32'h80, 3'd2, 32'hCAFEBABE); exp_resp(2, 32'h0);
    exp_issue(1'b0, 32'h1A5, 3'd1, 32'h0);       exp_resp(1, 32'h000000A5);
    exp_issue(1'b0, 32'h2000, 3'd4, 32'h0);      exp_resp(0, 32'hDFFF2000);
    fork
      do_store(32'h80, 3'd2, 32'hCAFEBABE);
      do_load(32'h1A5, 3'd1);
      do_fetch(32'h2000);
    join
    repeat (2) @(negedge clk_in);

    // starvation: fetch wins after four data grants despite a pending load
    exp_issue(1'b1, 32'h84, 3'd4, 32'h11223344); exp_resp(2, 32'h0);
    exp_issue(1'b0, 32'h400, 3'd4, 32'h0);       exp_resp(1, 32'hFBFF0400);
    exp_issue(1'b0, 32'h404, 3'd4, 32'h0);       exp_resp(1, 32'hFBFB0404);
    exp_issue(1'b0, 32'h408, 3'd4, 32'h0);       exp_resp(1, 32'hFBF70408);
    exp_issue(1'b0, 32'h2004, 3'd4, 32'h0);      exp_resp(0, 32'hDFFB2004);
    exp_issue(1'b0, 32'h40C, 3'd4, 32'h0);       exp_resp(1, 32'hFBF3040C);
    fork
      do_store(32'h84, 3'd4, 32'h11223344);
      begin
        do_load(32'h400, 3'd4); do_load(32'h404, 3'd4); do_load(32'h408, 3'd4); do_load(32'h40C, 3'd3);
      end
      do_fetch(32'h2004);
    join
    chk("starve_cnt_cleared", 32'(dut.starve_cnt_q), 0);
    repeat (2) @(negedge clk_in);

    // IO store blocked by full buffer; load goes first
    base = n_issue;
    io_buffer_full = 1'b1;
    exp_issue(1'b0, 32'h200, 3'd2, 32'h0);          exp_resp(1, 32'h00000200);
    exp_issue(1'b1, 32'h30000, 3'd1, 32'h778899AB); exp_resp(2, 32'h0);
    fork
      do_store(32'h30000, 3'd1, 32'h778899AB);
      do_load(32'h200, 3'd2);
      begin
        repeat (30) @(negedge clk_in);
        chk("io_store_held", 32'(n_issue - base), 1);
        io_buffer_full = 1'b0;
      end
    join
    repeat (2) @(negedge clk_in);

    // clear in the grant cycle cancels the fetch; it is granted once clear drops
    if_addr = 32'h3000; if_req = 1'b1; clear = 1'b1;
    @(negedge clk_in);
    clear = 1'b0;
    chk("clear_cancels_grant", 32'(dn_valid), 0);
    exp_issue(1'b0, 32'h3000, 3'd4, 32'h0); exp_resp(0, 32'hCFFF3000);
    do_fetch(32'h3000);
    repeat (2) @(negedge clk_in);

    // flush a load in BUSY: issued, but no ld_done
    exp_issue(1'b0, 32'h300, 3'd4, 32'h0);
    ld_addr = 32'h300; ld_len = 3'd4; ld_req = 1'b1;
    wait_issue();
    @(negedge clk_in);
    clear = 1'b1; ld_req = 1'b0;
    @(negedge clk_in);
    clear = 1'b0;
    repeat (10) @(negedge clk_in);

    // flush during a store: store still completes
    exp_issue(1'b1, 32'h88, 3'd4, 32'hA1B2C3D4); exp_resp(2, 32'h0);
    fork
      do_store(32'h88, 3'd4, 32'hA1B2C3D4);
      begin wait_issue(); @(negedge clk_in); clear = 1'b1; @(negedge clk_in); clear = 1'b0; end
    join
    repeat (2) @(negedge clk_in);

    // clear coincident with dn_done drops the fetch response
    exp_issue(1'b0, 32'h2008, 3'd4, 32'h0);
    if_addr = 32'h2008; if_req = 1'b1;
    wait_issue();
    repeat (3) @(negedge clk_in);
    clear = 1'b1; if_req = 1'b0;
    @(negedge clk_in);
    clear = 1'b0;
    repeat (8) @(negedge clk_in);

    // asynchronous reset in BUSY; a later stray dn_done is ignored
    ctl_en = 1'b0;
    exp_issue(1'b0, 32'h500, 3'd4, 32'h0);
    ld_addr = 32'h500; ld_len = 3'd4; ld_req = 1'b1;
    wait_issue();
    @(negedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    chk("arst_dn_addr", dn_addr, 0);
    chk("arst_dn_len", 32'(dn_len), 0);
    chk("arst_if_data", if_data, 0);
    chk("arst_ld_data", ld_data, 0);
    chk("arst_state", 32'(dut.state_q), 0);
    ld_req = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    kick++;
    repeat (8) @(negedge clk_in);
    chk("arst_state_after_stray_done", 32'(dut.state_q), 0);
    ctl_en = 1'b1;

    chk("exp_issue_drained", 32'(exp_dn.size()), 0);
    chk("exp_resp_drained", 32'(exp_rsp.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
